// File: rtl/vecgate_sweep_ctrl_if.sv
// Handshake and datapath bundle between the sweep controller and its environment.
// The controller takes the master side; the host plus vector-gate datapath take the slave side.
interface vecgate_sweep_ctrl_if;
    logic       start;
    logic [2:0] b_in;
    logic [2:0] dp_a;
    logic [2:0] dp_b;
    logic [2:0] dp_bitw;
    logic       dp_logic;
    logic [5:0] dp_not;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_a;
    logic [2:0] out_bitw;
    logic       out_logic;
    logic [5:0] out_not;
    logic       busy;
    logic       done;
    logic [3:0] err_cnt;

    modport master (
        input  start, b_in, dp_bitw, dp_logic, dp_not, out_ready,
        output dp_a, dp_b, out_valid, out_a, out_bitw, out_logic, out_not,
               busy, done, err_cnt
    );

    modport slave (
        output start, b_in, dp_bitw, dp_logic, dp_not, out_ready,
        input  dp_a, dp_b, out_valid, out_a, out_bitw, out_logic, out_not,
               busy, done, err_cnt
    );
endinterface

// File: rtl/vecgate_sweep_ctrl.sv
// Sweeps operand A from A_FIRST to A_LAST (mod 8) against a latched B, offering one result record per A.
// Optional golden-model checker enabled by macro SWEEP_CHECK_EN (drives err_cnt; tied to 0 otherwise).
module vecgate_sweep_ctrl #(
    parameter logic [2:0] A_FIRST = 3'd0,
    parameter logic [2:0] A_LAST  = 3'd7
) (
    input  logic               clk,
    input  logic               reset,
    vecgate_sweep_ctrl_if.master bus
);

    typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, OFFER, DONE} state_t;

    state_t     state;
    logic [2:0] a;
    logic [2:0] dp_a;
    logic [2:0] dp_b;
    logic       out_valid;
    logic [2:0] out_a;
    logic [2:0] out_bitw;
    logic       out_logic;
    logic [5:0] out_not;
    logic       busy;
    logic       done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a         <= 3'd0;
            dp_a      <= 3'd0;
            dp_b      <= 3'd0;
            out_valid <= 1'b0;
            out_a     <= 3'd0;
            out_bitw  <= 3'd0;
            out_logic <= 1'b0;
            out_not   <= 6'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // dp_b doubles as the latched B for the whole sweep
                        a     <= A_FIRST;
                        dp_a  <= A_FIRST;
                        dp_b  <= bus.b_in;
                        busy  <= 1'b1;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    out_a     <= a;
                    out_bitw  <= bus.dp_bitw;
                    out_logic <= bus.dp_logic;
                    out_not   <= bus.dp_not;
                    out_valid <= 1'b1;
                    state     <= OFFER;
                end
                OFFER: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (a == A_LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            a     <= a + 3'd1;
                            dp_a  <= a + 3'd1;
                            state <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    logic       mismatch;
    logic [3:0] err_cnt;

    // dp_a equals a and dp_b holds the latched B throughout CAPTURE
    always_comb begin
        mismatch = 1'b0;
        if (bus.dp_bitw != (dp_a | dp_b))                     mismatch = 1'b1;
        if (bus.dp_logic != ((dp_a != 3'd0) || (dp_b != 3'd0))) mismatch = 1'b1;
        if (bus.dp_not != {~dp_b, ~dp_a})                     mismatch = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 4'd0;
        end else if (state == IDLE && bus.start) begin
            err_cnt <= 4'd0;
        end else if (state == CAPTURE && mismatch && err_cnt != 4'hF) begin
            err_cnt <= err_cnt + 4'd1;
        end
    end

    assign bus.err_cnt = err_cnt;
`else
    assign bus.err_cnt = 4'd0;
`endif

    assign bus.dp_a      = dp_a;
    assign bus.dp_b      = dp_b;
    assign bus.out_valid = out_valid;
    assign bus.out_a     = out_a;
    assign bus.out_bitw  = out_bitw;
    assign bus.out_logic = out_logic;
    assign bus.out_not   = out_not;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_vecgate_sweep_ctrl.sv
// Scoreboard bench: three controllers (default, wrapping 6->1, single-record 5->5) with a behavioural datapath.
module tb_vecgate_sweep_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] bitw;
        logic       lg;
        logic [5:0] nt;
    } rec_t;

    vecgate_sweep_ctrl_if if0 ();
    vecgate_sweep_ctrl_if if1 ();
    vecgate_sweep_ctrl_if if2 ();

    logic [2:0] fault0 = 3'b111;

    assign if0.dp_bitw  = (if0.dp_a | if0.dp_b) & fault0;
    assign if0.dp_logic = |{if0.dp_a, if0.dp_b};
    assign if0.dp_not   = {~if0.dp_b, ~if0.dp_a};
    assign if1.dp_bitw  = if1.dp_a | if1.dp_b;
    assign if1.dp_logic = |{if1.dp_a, if1.dp_b};
    assign if1.dp_not   = {~if1.dp_b, ~if1.dp_a};
    assign if2.dp_bitw  = if2.dp_a | if2.dp_b;
    assign if2.dp_logic = |{if2.dp_a, if2.dp_b};
    assign if2.dp_not   = {~if2.dp_b, ~if2.dp_a};

    vecgate_sweep_ctrl dut0 (.clk(clk), .reset(reset), .bus(if0));
    vecgate_sweep_ctrl #(.A_FIRST(3'd6), .A_LAST(3'd1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    vecgate_sweep_ctrl #(.A_FIRST(3'd5), .A_LAST(3'd5)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    rec_t q0[$], q1[$], q2[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   dn0 = 0, dn1 = 0, dn2 = 0;
    int   t0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] mask);
        rec_t r;
        r.a    = a;
        r.bitw = (a | b) & mask;
        r.lg   = (a != 3'd0) || (b != 3'd0);
        r.nt   = {~b, ~a};
        return r;
    endfunction

    // Monitors: pop on every handshake, and check the record is frozen while stalled
    rec_t prev0, cur0, cur1, cur2;
    logic stall0 = 1'b0;
    always @(negedge clk) begin
        cur0 = {if0.out_a, if0.out_bitw, if0.out_logic, if0.out_not};
        if (reset) begin
            stall0 = 1'b0;
        end else begin
            if (if0.done) dn0++;
            if (stall0 && if0.out_valid) chk("hold0", cur0, prev0);
            if (if0.out_valid && if0.out_ready) begin
                if (q0.size() == 0) chk("extra_rec0", 1, 0);
                else                chk("rec0", cur0, q0.pop_front());
            end
            stall0 = if0.out_valid && !if0.out_ready;
            prev0  = cur0;
        end
    end

    always @(negedge clk) begin
        cur1 = {if1.out_a, if1.out_bitw, if1.out_logic, if1.out_not};
        if (!reset) begin
            if (if1.done) dn1++;
            if (if1.out_valid && if1.out_ready) begin
                if (q1.size() == 0) chk("extra_rec1", 1, 0);
                else                chk("rec1", cur1, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        cur2 = {if2.out_a, if2.out_bitw, if2.out_logic, if2.out_not};
        if (!reset) begin
            if (if2.done) dn2++;
            if (if2.out_valid && if2.out_ready) begin
                if (q2.size() == 0) chk("extra_rec2", 1, 0);
                else                chk("rec2", cur2, q2.pop_front());
            end
        end
    end

    task automatic go(input int k, input logic [2:0] b);
        @(negedge clk);
        case (k)
            0: begin if0.start = 1'b1; if0.b_in = b; end
            1: begin if1.start = 1'b1; if1.b_in = b; end
            default: begin if2.start = 1'b1; if2.b_in = b; end
        endcase
        @(posedge clk);
        #1;
        t0 = cyc;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
    endtask

    task automatic wait_done(input int k, output int lat);
        logic hit = 1'b0;
        lat = -1;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            case (k)
                0:       hit = if0.done;
                1:       hit = if1.done;
                default: hit = if2.done;
            endcase
        end
        if (hit) lat = cyc - t0;
        else     chk("timeout_done", 0, 1);
    endtask

    task automatic wait_dpa(input logic [2:0] v);
        logic hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = (if0.dp_a == v) && if0.busy;
        end
        if (!hit) chk("timeout_dpa", 0, 1);
    endtask

    task automatic wait_valid();
        logic hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = if0.out_valid;
        end
        if (!hit) chk("timeout_valid", 0, 1);
    endtask

    int lat;

    initial begin
        reset = 1'b1;
        if0.start = 1'b0; if0.b_in = 3'd0; if0.out_ready = 1'b1;
        if1.start = 1'b0; if1.b_in = 3'd0; if1.out_ready = 1'b1;
        if2.start = 1'b0; if2.b_in = 3'd0; if2.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_dp", {if0.dp_a, if0.dp_b}, 0);
        chk("rst_rec", {if0.out_valid, if0.out_a, if0.out_bitw, if0.out_logic, if0.out_not}, 0);
        chk("rst_status", {if0.busy, if0.done, if0.err_cnt}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Full default sweep, B=0, always ready
        for (int i = 0; i < 8; i++) q0.push_back(mk(3'(i), 3'd0, 3'b111));
        go(0, 3'd0);
        chk("busy_after_start", if0.busy, 1);
        wait_done(0, lat);
        chk("done_latency", lat, 24);
        @(negedge clk);
        chk("done_one_cycle", if0.done, 0);
        chk("idle_busy", if0.busy, 0);
        chk("done_count_a", dn0, 1);
        chk("q0_drained_a", q0.size(), 0);
        chk("err_clean_a", if0.err_cnt, 0);

        // B=7 with a 5-cycle stall at a=2; b_in and start toggled mid-sweep
        for (int i = 0; i < 8; i++) q0.push_back(mk(3'(i), 3'd7, 3'b111));
        go(0, 3'd7);
        wait_dpa(3'd2);
        if0.out_ready = 1'b0;
        if0.b_in = 3'd0;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        wait_valid();
        repeat (4) @(negedge clk);
        chk("stall_valid", if0.out_valid, 1);
        chk("stall_a", if0.out_a, 2);
        if0.out_ready = 1'b1;
        wait_done(0, lat);
        chk("dp_b_held", if0.dp_b, 7);
        repeat (10) @(negedge clk);
        chk("no_queued_start", dn0, 2);
        chk("busy_after_b", if0.busy, 0);
        chk("q0_drained_b", q0.size(), 0);

        // Reset while a=4 is pending in OFFER
        for (int i = 0; i < 4; i++) q0.push_back(mk(3'(i), 3'd1, 3'b111));
        go(0, 3'd1);
        wait_dpa(3'd4);
        if0.out_ready = 1'b0;
        wait_valid();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_status", {if0.out_valid, if0.busy, if0.done}, 0);
        chk("mid_rst_dp", {if0.dp_a, if0.dp_b}, 0);
        chk("mid_rst_rec", {if0.out_a, if0.out_bitw, if0.out_logic, if0.out_not}, 0);
        reset = 1'b0;
        if0.out_ready = 1'b1;
        chk("q0_drained_c", q0.size(), 0);
        for (int i = 0; i < 8; i++) q0.push_back(mk(3'(i), 3'd0, 3'b111));
        go(0, 3'd0);
        wait_done(0, lat);
        chk("restart_latency", lat, 24);

        // Wrapping sweep 6,7,0,1
        q1.push_back(mk(3'd6, 3'd2, 3'b111));
        q1.push_back(mk(3'd7, 3'd2, 3'b111));
        q1.push_back(mk(3'd0, 3'd2, 3'b111));
        q1.push_back(mk(3'd1, 3'd2, 3'b111));
        go(1, 3'd2);
        wait_done(1, lat);
        chk("wrap_latency", lat, 12);

        // Single-record sweep
        q2.push_back(mk(3'd5, 3'd0, 3'b111));
        go(2, 3'd0);
        wait_done(2, lat);
        chk("single_latency", lat, 3);

`ifdef SWEEP_CHECK_EN
        // dp_bitw bit0 stuck at 0: odd A values mismatch
        fault0 = 3'b110;
        for (int i = 0; i < 8; i++) q0.push_back(mk(3'(i), 3'd0, 3'b110));
        go(0, 3'd0);
        wait_done(0, lat);
        chk("err_cnt_fault", if0.err_cnt, 4);
        fault0 = 3'b111;
        q0.push_back(mk(3'd0, 3'd0, 3'b111));
        go(0, 3'd0);
        chk("err_cnt_clear", if0.err_cnt, 0);
        wait_done(0, lat);
        q0.delete();
`endif

        repeat (3) @(negedge clk);
        chk("q0_final", q0.size(), 0);
        chk("q1_final", q1.size(), 0);
        chk("q2_final", q2.size(), 0);
        chk("done_count_1", dn1, 1);
        chk("done_count_2", dn2, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vecgate_sweep_ctrl.md
VECGATE_SWEEP_CTRL -- requirements
Module: vecgate_sweep_ctrl

Interface
REQ-001 SHALL have parameter A_FIRST, default 3'd0: first A operand of a sweep.
REQ-002 SHALL have parameter A_LAST, default 3'd7: last A operand of a sweep.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request a sweep; sampled only in IDLE.
REQ-006 SHALL have port b_in  in  3  B operand latched at an accepted start.
REQ-007 SHALL have ports dp_a, dp_b  out  3 each  operands driven to the vector-gate datapath.
REQ-008 SHALL have ports dp_bitw (in 3), dp_logic (in 1), dp_not (in 6)  combinational datapath results.
REQ-009 SHALL have ports out_valid (out 1), out_ready (in 1)  result handshake.
REQ-010 SHALL have ports out_a (out 3), out_bitw (out 3), out_logic (out 1), out_not (out 6)  registered result record.
REQ-011 SHALL have ports busy (out 1), done (out 1), err_cnt (out 4)  status.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, CAPTURE, OFFER, DONE.
REQ-013 IDLE: start=1 -> latch b_in, load a=A_FIRST, go to DRIVE; start=0 -> stay.
REQ-014 DRIVE: dp_a=a, dp_b=latched B for one cycle (settle); then CAPTURE.
REQ-015 CAPTURE: register out_a=a, out_bitw/out_logic/out_not from datapath; then OFFER.
REQ-016 OFFER: out_valid=1, record held stable until the cycle out_valid&&out_ready.
REQ-017 OFFER handshake with a==A_LAST -> DONE; otherwise a=(a+1) mod 8 -> DRIVE.
REQ-018 DONE: done=1 for exactly one cycle; then IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 start while busy SHALL be ignored; no queueing.
REQ-021 A_LAST < A_FIRST SHALL wrap through 7->0; records per sweep = ((A_LAST-A_FIRST) mod 8)+1.
REQ-022 A_FIRST==A_LAST SHALL yield exactly one record.
REQ-023 Minimum cycles per record SHALL be 3 (DRIVE, CAPTURE, OFFER with out_ready=1).
REQ-024 dp_a/dp_b SHALL hold their last values outside DRIVE; b_in changes mid-sweep have no effect.

Reset
REQ-025 reset=1 SHALL force IDLE on the next edge, overriding any state, including mid-sweep.
REQ-026 Reset values: dp_a, dp_b, out_a, out_bitw, out_not = 0; out_valid, out_logic, busy, done = 0; err_cnt = 0.
REQ-027 A record pending in OFFER at reset SHALL be discarded without handshake.

Configuration
REQ-028 Macro SWEEP_CHECK_EN defined: in CAPTURE, compare datapath results with internal golden (bitw=A|B, logic=(A!=0)||(B!=0), not={~B,~A}); each mismatch increments err_cnt, saturating at 15; cleared at accepted start and at reset.
REQ-029 SWEEP_CHECK_EN undefined: no compare logic; err_cnt tied to 0; port list unchanged.

Verification
REQ-030 Default params, b_in=3'b000, start, out_ready=1 -> 8 records a=0..7, out_bitw=a, out_logic=(a!=0), out_not={3'b111,~a}; done pulse once, 24 cycles after start.
REQ-031 b_in=3'b111, out_ready held 0 for 5 cycles at a=2 -> record a=2 held unchanged with out_valid=1, released on ready, next record a=3.
REQ-032 A_FIRST=6, A_LAST=1 -> records in order 6,7,0,1, then done.
REQ-033 reset asserted in OFFER at a=4 -> next cycle IDLE, out_valid=0, busy=0, all outputs 0; new start restarts from A_FIRST.
REQ-034 start pulsed while busy -> ignored; exactly one sweep, one done pulse.
REQ-035 SWEEP_CHECK_EN defined, datapath model with dp_bitw bit0 stuck at 0, b_in=0 -> err_cnt=4 at done (a=1,3,5,7).
